// File: rtl/ps2_mouse_tracker_if.sv
// Bus between the PS/2 byte receiver, the mouse tracker and the drawing stage.
// rx_valid is a one-cycle strobe with no back-pressure: the tracker takes rx_data in the same cycle.
interface ps2_mouse_tracker_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       mouse_left;
    logic       mouse_right;
    logic       mouse_middle;
    logic       pkt_update;
    logic       sync_err;
    logic [1:0] state_dbg;

    modport master (
        output rx_data, rx_valid,
        input  mouse_x, mouse_y, mouse_left, mouse_right, mouse_middle,
        input  pkt_update, sync_err, state_dbg
    );

    modport slave (
        input  rx_data, rx_valid,
        output mouse_x, mouse_y, mouse_left, mouse_right, mouse_middle,
        output pkt_update, sync_err, state_dbg
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and integrates the deltas into a clamped
// absolute cursor with button levels for the drawing stage and cursor overlay.
module ps2_mouse_tracker #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int TIMEOUT  = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_mouse_tracker_if.slave   bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]        TO_LAST = CW'(TIMEOUT - 1);
    localparam logic signed [11:0]   X_MAX   = 12'(SCREEN_W - 1);
    localparam logic signed [11:0]   Y_MAX   = 12'(SCREEN_H - 1);
    localparam logic [9:0]           X_RST   = 10'(SCREEN_W / 2);
    localparam logic [9:0]           Y_RST   = 10'(SCREEN_H / 2);

    typedef enum logic [1:0] {BYTE0 = 2'd0, BYTE1 = 2'd1, BYTE2 = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      btn_pend_q, btn_pend_d;
    logic            xs_q, xs_d, ys_q, ys_d, xo_q, xo_d, yo_q, yo_d;
    logic [7:0]      xbyte_q, xbyte_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [2:0]      btn_q, btn_d;
    logic            pkt_q, pkt_d;
    logic            serr_q, serr_d;

    logic signed [11:0] dx, dy, nx, ny;

    function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                         input logic signed [11:0] vmax);
        if (v < 12'sd0)
            clamp = '0;
        else if (v > vmax)
            clamp = vmax[9:0];
        else
            clamp = v[9:0];
    endfunction

    // Byte 2 carries the Y data directly; only status and X byte need latching.
    always_comb begin
        dx = xo_q ? 12'sd0 : {{3{xs_q}}, xs_q, xbyte_q};
        dy = yo_q ? 12'sd0 : {{3{ys_q}}, ys_q, bus.rx_data};
        nx = $signed({2'b00, x_q}) + dx;
        ny = $signed({2'b00, y_q}) - dy;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        btn_pend_d = btn_pend_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        xo_d       = xo_q;
        yo_d       = yo_q;
        xbyte_d    = xbyte_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        pkt_d      = 1'b0;
        serr_d     = 1'b0;

        if (bus.rx_valid) begin
            cnt_d = '0;
            case (state_q)
                BYTE0: begin
                    if (bus.rx_data[3]) begin
                        btn_pend_d = bus.rx_data[2:0];
                        xs_d       = bus.rx_data[4];
                        ys_d       = bus.rx_data[5];
                        xo_d       = bus.rx_data[6];
                        yo_d       = bus.rx_data[7];
                        state_d    = BYTE1;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
                BYTE1: begin
                    xbyte_d = bus.rx_data;
                    state_d = BYTE2;
                end
                BYTE2: begin
                    x_d     = clamp(nx, X_MAX);
                    y_d     = clamp(ny, Y_MAX);
                    btn_d   = btn_pend_q;
                    pkt_d   = 1'b1;
                    state_d = BYTE0;
                end
                default: state_d = BYTE0;
            endcase
        end else if (state_q != BYTE0) begin
            // A stalled partial packet is dropped silently so the next status byte resyncs.
            if (cnt_q == TO_LAST) begin
                state_d = BYTE0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BYTE0;
            cnt_q      <= '0;
            btn_pend_q <= '0;
            xs_q       <= 1'b0;
            ys_q       <= 1'b0;
            xo_q       <= 1'b0;
            yo_q       <= 1'b0;
            xbyte_q    <= '0;
            x_q        <= X_RST;
            y_q        <= Y_RST;
            btn_q      <= '0;
            pkt_q      <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_pend_q <= btn_pend_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            xo_q       <= xo_d;
            yo_q       <= yo_d;
            xbyte_q    <= xbyte_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            pkt_q      <= pkt_d;
            serr_q     <= serr_d;
        end
    end

    assign bus.mouse_x      = x_q;
    assign bus.mouse_y      = y_q;
    assign bus.mouse_left   = btn_q[0];
    assign bus.mouse_right  = btn_q[1];
    assign bus.mouse_middle = btn_q[2];
    assign bus.pkt_update   = pkt_q;
    assign bus.sync_err     = serr_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: a cursor model pushes expected packet
// results to a queue; a monitor pops and compares on every pkt_update.
module tb_ps2_mouse_tracker;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_mouse_tracker_if bus ();

    ps2_mouse_tracker #(.SCREEN_W(W), .SCREEN_H(H), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [22:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    int serr_seen = 0;
    int pkts_sent = 0;
    int mx, my;
    logic [2:0] mbtn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
        return v;
    endfunction

    // Scoreboard side: compare each applied packet against the model's prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sync_err) serr_seen++;
            if (bus.pkt_update) begin
                upd_seen++;
                check("queue_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("pkt_word",
                          {9'd0, bus.mouse_x, bus.mouse_y, bus.mouse_middle, bus.mouse_right, bus.mouse_left},
                          {9'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx   = clampi(mx + dx, W);
        my   = clampi(my - dy, H);
        mbtn = b0[2:0];
        exp_q.push_back({10'(mx), 10'(my), mbtn});
        pkts_sent++;
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mx = W / 2;
        my = H / 2;
        mbtn = 3'b000;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"}, 32'(bus.mouse_x), 32'(mx));
        check({tag, "_y"}, 32'(bus.mouse_y), 32'(my));
        check({tag, "_btn"}, {29'd0, bus.mouse_middle, bus.mouse_right, bus.mouse_left}, {29'd0, mbtn});
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        mx = W / 2;
        my = H / 2;
        mbtn = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_x", 32'(bus.mouse_x), 32'd320);
        check("rst_y", 32'(bus.mouse_y), 32'd240);
        check("rst_btn", {29'd0, bus.mouse_middle, bus.mouse_right, bus.mouse_left}, 32'd0);
        check("rst_pkt_update", 32'(bus.pkt_update), 32'd0);
        check("rst_sync_err", 32'(bus.sync_err), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'd0);

        // Basic packet, one-cycle latency and one-cycle pulse.
        send_pkt(8'h09, 8'h05, 8'h03);
        check("p1_x", 32'(bus.mouse_x), 32'd325);
        check("p1_y", 32'(bus.mouse_y), 32'd237);
        check("p1_left", 32'(bus.mouse_left), 32'd1);
        check("p1_pulse", 32'(bus.pkt_update), 32'd1);
        @(negedge clk);
        check("p1_pulse_end", 32'(bus.pkt_update), 32'd0);
        check("p1_hold_x", 32'(bus.mouse_x), 32'd325);

        // Negative X walks to the left edge and clamps.
        do_reset();
        send_pkt(8'h18, 8'h80, 8'h00);
        check("neg1_x", 32'(bus.mouse_x), 32'd192);
        send_pkt(8'h18, 8'h80, 8'h00);
        check("neg2_x", 32'(bus.mouse_x), 32'd64);
        send_pkt(8'h18, 8'h80, 8'h00);
        check("neg3_x", 32'(bus.mouse_x), 32'd0);
        check("neg3_y", 32'(bus.mouse_y), 32'd240);

        // Y direction is inverted and clamps at the bottom row.
        send_pkt(8'h28, 8'h00, 8'h01);
        check("ybot_y", 32'(bus.mouse_y), 32'd479);
        send_pkt(8'h08, 8'h00, 8'h7F);
        check("yup_y", 32'(bus.mouse_y), 32'd352);

        // X overflow suppresses dx; Y and buttons still apply.
        send_pkt(8'h4A, 8'h7F, 8'h10);
        check("xovf_x", 32'(bus.mouse_x), 32'd0);
        check("xovf_y", 32'(bus.mouse_y), 32'd336);
        check("xovf_right", 32'(bus.mouse_right), 32'd1);
        check("xovf_left", 32'(bus.mouse_left), 32'd0);

        // Bad sync bit is discarded with a pulse.
        send_byte(8'h05);
        check("sync_pulse", 32'(bus.sync_err), 32'd1);
        check("sync_state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        check("sync_pulse_end", 32'(bus.sync_err), 32'd0);
        send_pkt(8'h08, 8'h01, 8'h00);
        check("after_sync_x", 32'(bus.mouse_x), 32'd1);

        // Stalled partial packet times out; next packet applies alone.
        send_byte(8'h08);
        send_byte(8'h02);
        check("partial_state", 32'(bus.state_dbg), 32'd2);
        repeat (TO + 4) @(negedge clk);
        check("timeout_state", 32'(bus.state_dbg), 32'd0);
        check("timeout_hold_x", 32'(bus.mouse_x), 32'd1);
        send_pkt(8'h08, 8'h03, 8'h00);
        check("after_to_x", 32'(bus.mouse_x), 32'd4);

        // Right and top edges, plus middle button.
        do_reset();
        send_pkt(8'h0C, 8'hFF, 8'h00);
        send_pkt(8'h0C, 8'hFF, 8'hFF);
        check_model("edge");
        check("edge_x", 32'(bus.mouse_x), 32'd639);
        check("edge_y", 32'(bus.mouse_y), 32'd0);
        check("edge_mid", 32'(bus.mouse_middle), 32'd1);

        // Reset in the middle of a packet.
        send_byte(8'h09);
        send_byte(8'h05);
        do_reset();
        check_model("midrst");
        check("midrst_state", 32'(bus.state_dbg), 32'd0);
        send_pkt(8'h09, 8'h05, 8'h03);
        check("midrst_pkt_x", 32'(bus.mouse_x), 32'd325);
        check("midrst_pkt_y", 32'(bus.mouse_y), 32'd237);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("update_count", 32'(upd_seen), 32'(pkts_sent));
        check("sync_err_count", 32'(serr_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
